// File: rtl/atm_pin_auth_if.sv
// Bus bundle for the ATM PIN authentication stage.
// The master side (transaction controller or bench) drives the requests.
// The slave side (atm_pin_auth) returns the session status.
interface atm_pin_auth_if;
    logic       start;
    logic [3:0] account_id;
    logic       pin_valid;
    logic [3:0] pin_in;
    logic       chg_req;
    logic [3:0] new_pin;
    logic       session_end;
    logic       busy;
    logic       auth_ok;
    logic       fail_pulse;
    logic       rejected;
    logic       locked;
    logic [1:0] tries_left;
    logic       chg_done;

    modport master (
        output start, account_id, pin_valid, pin_in, chg_req, new_pin, session_end,
        input  busy, auth_ok, fail_pulse, rejected, locked, tries_left, chg_done
    );

    modport slave (
        input  start, account_id, pin_valid, pin_in, chg_req, new_pin, session_end,
        output busy, auth_ok, fail_pulse, rejected, locked, tries_left, chg_done
    );
endinterface

// File: rtl/atm_pin_auth.sv
// PIN authentication stage for the ATM front end.
// Checks the account ID and collects PIN attempts with an idle timeout.
// Locks the account after MAX_TRIES misses and services PIN changes once authenticated.
// All status outputs are registered from the next state, so they change together with the state.
module atm_pin_auth #(
    parameter int NUM_ACCOUNTS = 4,
    parameter int MAX_TRIES    = 3,
    parameter int TIMEOUT_CYC  = 255
) (
    input logic          clk,
    input logic          rst,
    atm_pin_auth_if.slave bus
);

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYC);
    localparam logic [1:0] TRIES   = 2'(MAX_TRIES);
    localparam logic [4:0] NUM     = 5'(NUM_ACCOUNTS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK_ID = 3'd1,
        S_WAIT_PIN = 3'd2,
        S_COMPARE  = 3'd3,
        S_AUTHED   = 3'd4,
        S_LOCKED   = 3'd5,
        S_REJECT   = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;

    // Session counters and their next values
    logic [1:0]  fail_cnt;
    logic [1:0]  fail_cnt_nx;
    logic [7:0]  timer;
    logic [7:0]  timer_nx;

    // Session data captured from the bus (not reset: only meaningful once captured)
    logic [3:0]  id_q;
    logic [3:0]  pin_q;

    // Tables are sized for the 4-bit account space so any id indexes safely;
    // only entries below NUM_ACCOUNTS are ever written or trusted.
    logic [15:0] lock_flags;
    logic [3:0]  pin_tab [16];

    logic        pin_match;
    logic        id_bad;
    logic        last_try;
    logic        id_take;
    logic        pin_take;
    logic        chg_write;
    logic        lock_set;

    // Next-value outputs feeding the output register
    logic        busy_d;
    logic        auth_ok_d;
    logic        fail_pulse_d;
    logic        rejected_d;
    logic        locked_d;
    logic [1:0]  tries_left_d;
    logic        chg_done_d;

    assign pin_match = (pin_q == pin_tab[id_q]);
    assign id_bad    = ({1'b0, id_q} >= NUM) || lock_flags[id_q];
    assign last_try  = ((fail_cnt + 2'd1) == TRIES);
    assign id_take   = (state == S_IDLE) && bus.start;
    assign pin_take  = (state == S_WAIT_PIN) && !bus.session_end && bus.pin_valid;
    // A simultaneous session_end cancels the change request.
    assign chg_write = (state == S_AUTHED) && bus.chg_req && !bus.session_end;
    assign lock_set  = (state == S_COMPARE) && !pin_match && last_try;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and session counter update rules
    always_comb begin
        next_state  = state;
        fail_cnt_nx = fail_cnt;
        timer_nx    = timer;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_CHECK_ID;
                end
            end
            S_CHECK_ID: begin
                fail_cnt_nx = '0;
                timer_nx    = '0;
                next_state  = id_bad ? S_REJECT : S_WAIT_PIN;
            end
            S_WAIT_PIN: begin
                if (bus.session_end) begin
                    next_state = S_IDLE;
                end else if (bus.pin_valid) begin
                    next_state = S_COMPARE;
                end else if (timer == TIMEOUT) begin
                    next_state = S_REJECT;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            S_COMPARE: begin
                if (pin_match) begin
                    next_state = S_AUTHED;
                end else if (last_try) begin
                    // Saturate the count so tries_left reads zero while locked.
                    fail_cnt_nx = TRIES;
                    next_state  = S_LOCKED;
                end else begin
                    fail_cnt_nx = fail_cnt + 2'd1;
                    timer_nx    = '0;
                    next_state  = S_WAIT_PIN;
                end
            end
            S_AUTHED, S_LOCKED, S_REJECT: begin
                if (bus.session_end) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state
    always_comb begin
        busy_d       = (next_state != S_IDLE);
        auth_ok_d    = (next_state == S_AUTHED);
        rejected_d   = (next_state == S_REJECT);
        locked_d     = (next_state == S_LOCKED);
        fail_pulse_d = (state == S_COMPARE) && !pin_match && !last_try;
        chg_done_d   = chg_write;
        tries_left_d = TRIES - fail_cnt_nx;
    end

    // Session counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            fail_cnt <= fail_cnt_nx;
            timer    <= timer_nx;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy       <= 1'b0;
            bus.auth_ok    <= 1'b0;
            bus.fail_pulse <= 1'b0;
            bus.rejected   <= 1'b0;
            bus.locked     <= 1'b0;
            bus.tries_left <= TRIES;
            bus.chg_done   <= 1'b0;
        end else begin
            bus.busy       <= busy_d;
            bus.auth_ok    <= auth_ok_d;
            bus.fail_pulse <= fail_pulse_d;
            bus.rejected   <= rejected_d;
            bus.locked     <= locked_d;
            bus.tries_left <= tries_left_d;
            bus.chg_done   <= chg_done_d;
        end
    end

    // Capture account id on an accepted start and the PIN attempt on an accepted strobe
    always_ff @(posedge clk) begin
        if (id_take) begin
            id_q <= bus.account_id;
        end
        if (pin_take) begin
            pin_q <= bus.pin_in;
        end
    end

    // PIN table and lock flags; reset restores the factory PINs and clears all locks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_flags <= '0;
            for (int i = 0; i < 16; i++) begin
                pin_tab[i] <= 4'(i);
            end
        end else begin
            if (chg_write) begin
                pin_tab[id_q] <= bus.new_pin;
            end
            if (lock_set) begin
                lock_flags[id_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atm_pin_auth.sv
// Self-checking bench for atm_pin_auth: directed table, multi-cycle corner cases,
// then random sessions checked against a session-level model of PINs and locks.
module tb_atm_pin_auth;

    localparam int NUM_ACC = 4;
    localparam int TRIES   = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    atm_pin_auth_if bus ();

    atm_pin_auth #(
        .NUM_ACCOUNTS(NUM_ACC),
        .MAX_TRIES   (TRIES),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] id;
        int         npins;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] p2;
        int         exp_auth;
        int         exp_locked;
        int         exp_rej;
        int         exp_pulses;
        int         exp_tries;
    } vec_t;

    vec_t vecs [7];

    // Session-level reference: current PIN and lock flag per account
    logic [3:0] m_pin  [16];
    bit         m_lock [16];

    logic [3:0] cur_id;
    logic [3:0] cur_pin;
    logic [3:0] nxt_pin;
    logic [3:0] tp;
    int         fails;
    int         pulses;
    bit         done;

    function automatic vec_t mk(input logic [3:0] id, input int n, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] c, input int au,
                                input int lk, input int rj, input int pu, input int tr);
        vec_t v;
        v.id = id; v.npins = n; v.p0 = a; v.p1 = b; v.p2 = c;
        v.exp_auth = au; v.exp_locked = lk; v.exp_rej = rj;
        v.exp_pulses = pu; v.exp_tries = tr;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_session(input logic [3:0] id);
        bus.account_id = id;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
    endtask

    task automatic attempt(input logic [3:0] p);
        bus.pin_in = p;
        bus.pin_valid = 1'b1;
        step();
        bus.pin_valid = 1'b0;
        step();
    endtask

    task automatic end_session();
        bus.session_end = 1'b1;
        step();
        bus.session_end = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pin[i]  = 4'(i);
            m_lock[i] = 1'b0;
        end
    endtask

    function automatic logic [3:0] pick(input vec_t v, input int j);
        if (j == 0) return v.p0;
        if (j == 1) return v.p1;
        return v.p2;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.account_id = '0; bus.pin_valid = 1'b0; bus.pin_in = '0;
        bus.chg_req = 1'b0; bus.new_pin = '0; bus.session_end = 1'b0;

        vecs[0] = mk(4'd2, 1, 4'd2, 4'd0, 4'd0, 1, 0, 0, 0, 3);
        vecs[1] = mk(4'd1, 2, 4'd5, 4'd1, 4'd0, 1, 0, 0, 1, 2);
        vecs[2] = mk(4'd3, 3, 4'd0, 4'd1, 4'd2, 0, 1, 0, 2, 0);
        vecs[3] = mk(4'd3, 0, 4'd3, 4'd0, 4'd0, 0, 0, 1, 0, 3);
        vecs[4] = mk(4'd4, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 3);
        vecs[5] = mk(4'd9, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 3);
        vecs[6] = mk(4'd2, 3, 4'd7, 4'd6, 4'd2, 1, 0, 0, 2, 1);

        repeat (2) step();
        rst = 1'b0;

        check("rst_busy", int'(bus.busy), 0);
        check("rst_auth_ok", int'(bus.auth_ok), 0);
        check("rst_fail_pulse", int'(bus.fail_pulse), 0);
        check("rst_rejected", int'(bus.rejected), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_chg_done", int'(bus.chg_done), 0);
        check("rst_tries_left", int'(bus.tries_left), 3);

        // pin_valid while idle is ignored
        attempt(4'd0);
        check("idle_pin_ignored_busy", int'(bus.busy), 0);
        check("idle_pin_ignored_auth", int'(bus.auth_ok), 0);

        // Directed table
        for (int k = 0; k < 7; k++) begin
            begin_session(vecs[k].id);
            check("tbl_busy", int'(bus.busy), 1);
            pulses = 0;
            for (int j = 0; j < vecs[k].npins; j++) begin
                attempt(pick(vecs[k], j));
                pulses += int'(bus.fail_pulse);
            end
            check($sformatf("tbl%0d_auth", k), int'(bus.auth_ok), vecs[k].exp_auth);
            check($sformatf("tbl%0d_locked", k), int'(bus.locked), vecs[k].exp_locked);
            check($sformatf("tbl%0d_rejected", k), int'(bus.rejected), vecs[k].exp_rej);
            check($sformatf("tbl%0d_pulses", k), pulses, vecs[k].exp_pulses);
            check($sformatf("tbl%0d_tries", k), int'(bus.tries_left), vecs[k].exp_tries);
            end_session();
            check($sformatf("tbl%0d_idle", k), int'(bus.busy), 0);
        end

        // PIN change, start ignored while authenticated
        begin_session(4'd1);
        attempt(4'd1);
        check("chg_auth", int'(bus.auth_ok), 1);
        bus.account_id = 4'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_ignored_auth", int'(bus.auth_ok), 1);
        bus.new_pin = 4'd7;
        bus.chg_req = 1'b1;
        step();
        bus.chg_req = 1'b0;
        check("chg_done_pulse", int'(bus.chg_done), 1);
        step();
        check("chg_done_clear", int'(bus.chg_done), 0);
        check("chg_auth_hold", int'(bus.auth_ok), 1);
        end_session();
        begin_session(4'd1);
        attempt(4'd1);
        check("chg_old_pin_fail", int'(bus.fail_pulse), 1);
        check("chg_old_pin_tries", int'(bus.tries_left), 2);
        attempt(4'd7);
        check("chg_new_pin_auth", int'(bus.auth_ok), 1);

        // chg_req together with session_end: exit wins, no write
        bus.new_pin = 4'd9;
        bus.chg_req = 1'b1;
        bus.session_end = 1'b1;
        step();
        bus.chg_req = 1'b0;
        bus.session_end = 1'b0;
        check("conflict_idle", int'(bus.busy), 0);
        check("conflict_no_done", int'(bus.chg_done), 0);
        begin_session(4'd1);
        attempt(4'd7);
        check("conflict_pin_kept", int'(bus.auth_ok), 1);
        end_session();

        // Timeout: 255 idle cycles tolerated, the 256th rejects
        begin_session(4'd0);
        repeat (255) step();
        check("timeout_edge_not_rej", int'(bus.rejected), 0);
        check("timeout_edge_busy", int'(bus.busy), 1);
        step();
        check("timeout_rej", int'(bus.rejected), 1);
        attempt(4'd0);
        check("rej_pin_ignored", int'(bus.auth_ok), 0);
        check("rej_hold", int'(bus.rejected), 1);
        end_session();
        check("timeout_idle", int'(bus.busy), 0);

        // Asynchronous reset mid-session restores table and locks
        begin_session(4'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_tries", int'(bus.tries_left), 3);
        step();
        rst = 1'b0;
        begin_session(4'd3);
        check("arst_unlock_not_rej", int'(bus.rejected), 0);
        attempt(4'd3);
        check("arst_unlock_auth", int'(bus.auth_ok), 1);
        end_session();
        begin_session(4'd1);
        attempt(4'd1);
        check("arst_table_restored", int'(bus.auth_ok), 1);
        end_session();

        // Random sessions against the model
        model_reset();
        for (int s = 0; s < 60; s++) begin
            cur_id = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) cur_id = 4'd15;
            begin_session(cur_id);
            if (int'(cur_id) >= NUM_ACC || m_lock[cur_id]) begin
                check("rnd_rejected", int'(bus.rejected), 1);
                check("rnd_rej_auth", int'(bus.auth_ok), 0);
            end else begin
                check("rnd_tries_start", int'(bus.tries_left), TRIES);
                fails = 0;
                done = 1'b0;
                while (!done) begin
                    repeat ($urandom_range(0, 4)) step();
                    if ($urandom_range(0, 1) == 1) begin
                        cur_pin = m_pin[cur_id];
                    end else begin
                        cur_pin = 4'($urandom_range(0, 15));
                    end
                    attempt(cur_pin);
                    if (cur_pin == m_pin[cur_id]) begin
                        check("rnd_auth", int'(bus.auth_ok), 1);
                        check("rnd_auth_tries", int'(bus.tries_left), TRIES - fails);
                        done = 1'b1;
                        if ($urandom_range(0, 2) == 0) begin
                            nxt_pin = 4'($urandom_range(0, 15));
                            bus.new_pin = nxt_pin;
                            bus.chg_req = 1'b1;
                            step();
                            bus.chg_req = 1'b0;
                            check("rnd_chg_done", int'(bus.chg_done), 1);
                            m_pin[cur_id] = nxt_pin;
                            step();
                            check("rnd_chg_clear", int'(bus.chg_done), 0);
                        end
                    end else begin
                        fails++;
                        if (fails == TRIES) begin
                            check("rnd_locked", int'(bus.locked), 1);
                            check("rnd_locked_tries", int'(bus.tries_left), 0);
                            m_lock[cur_id] = 1'b1;
                            done = 1'b1;
                        end else begin
                            check("rnd_fail_pulse", int'(bus.fail_pulse), 1);
                            check("rnd_fail_tries", int'(bus.tries_left), TRIES - fails);
                            step();
                            check("rnd_pulse_clear", int'(bus.fail_pulse), 0);
                        end
                    end
                end
            end
            end_session();
            check("rnd_idle", int'(bus.busy), 0);
        end

        // Confirm every account's final PIN/lock state as the model sees it
        for (int a = 0; a < NUM_ACC; a++) begin
            tp = 4'(a);
            begin_session(tp);
            check("final_rej", int'(bus.rejected), int'(m_lock[tp]));
            if (!m_lock[tp]) begin
                attempt(m_pin[tp]);
                check("final_auth", int'(bus.auth_ok), 1);
            end
            end_session();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
